// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: owns the PC, issues one instruction-memory read at a
// time, holds the fetched word for decode, and applies jump/branch/flush redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    input  logic            stall,
    input  logic            jump,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] drain_addr_q, drain_addr_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    logic [PC_W-1:0] pc_plus4_w;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] flush_target;

    assign pc_plus4_w    = pc_q + 32'd4;
    assign jump_target   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc_plus4_w + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign flush_target  = flush_pc & ~32'd3;

    always_comb begin
        if (jump)              next_pc = jump_target;
        else if (branch_taken) next_pc = branch_target;
        else                   next_pc = pc_plus4_w;
    end

    // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        if (flush) begin
            pc_d    = flush_target;
            valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                S_HOLD:  state_d = S_REQ;
                // A read completing on the same edge as a repeat flush needs no further draining.
                S_DRAIN: state_d = imem_valid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_valid) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_d    = next_pc;
                        valid_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    // The request is masked during reset so memory sees nothing while the state settles.
    assign imem_req    = !reset && ((state_q == S_REQ) || (state_q == S_DRAIN));
    assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change on the falling edge, outputs are
// checked on the falling edge against hand-computed values.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        flush;
    logic [31:0] flush_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .flush        (flush),
        .flush_pc     (flush_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expects a pending request at addr, answers after lat idle cycles, then checks HOLD.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input int lat);
        check({tag, " req"}, {31'd0, imem_req}, 32'd1);
        check({tag, " addr"}, imem_addr, addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check({tag, " wait req"}, {31'd0, imem_req}, 32'd1);
            check({tag, " wait valid"}, {31'd0, instr_valid}, 32'd0);
        end
        imem_valid = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, " instr"}, instr, data);
        check({tag, " pc"}, pc, addr);
        check({tag, " pc_plus4"}, pc_plus4, addr + 32'd4);
        check({tag, " hold req"}, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic accept(input string tag, input logic j, input logic bt,
                          input logic [15:0] off, input logic [31:0] exp_next);
        stall         = 1'b0;
        jump          = j;
        branch_taken  = bt;
        branch_offset = off;
        @(negedge clk);
        stall         = 1'b1;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'd0;
        check({tag, " valid dropped"}, {31'd0, instr_valid}, 32'd0);
        check({tag, " next addr"}, imem_addr, exp_next);
    endtask

    initial begin
        reset         = 1'b1;
        imem_valid    = 1'b0;
        imem_rdata    = 32'd0;
        stall         = 1'b1;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'd0;
        flush         = 1'b0;
        flush_pc      = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset req", {31'd0, imem_req}, 32'd0);
        check("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        check("reset pc", pc, 32'h0);
        check("reset pc_plus4", pc_plus4, 32'h4);
        check("reset instr", instr, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // First fetch, then a 3-cycle stall
        fetch("first", 32'h0, 32'h2008_0005, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall instr", instr, 32'h2008_0005);
            check("stall pc", pc, 32'h0);
            check("stall valid", {31'd0, instr_valid}, 32'd1);
            check("stall req", {31'd0, imem_req}, 32'd0);
        end
        accept("seq", 1'b0, 1'b0, 16'd0, 32'h4);

        // Flush in HOLD with jump asserted: jump ignored, flush_pc taken
        fetch("at4", 32'h4, 32'h0000_0000, 0);
        flush    = 1'b1;
        flush_pc = 32'h0040_0010;
        stall    = 1'b0;
        jump     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b1;
        jump  = 1'b0;
        check("hold flush valid", {31'd0, instr_valid}, 32'd0);

        // Jump, then jump together with branch
        fetch("jmp", 32'h0040_0010, 32'h0810_0020, 0);
        accept("jump", 1'b1, 1'b0, 16'd0, 32'h0040_0080);
        fetch("jmp2", 32'h0040_0080, 32'h0810_0020, 2);
        accept("jump wins", 1'b1, 1'b1, 16'h0003, 32'h0040_0080);

        // Branches backward and forward from pc=0x100
        fetch("pre br", 32'h0040_0080, 32'h0000_0000, 0);
        flush    = 1'b1;
        flush_pc = 32'h0000_0100;
        stall    = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b1;
        fetch("br1", 32'h100, 32'h1000_FFFE, 0);
        accept("branch back", 1'b0, 1'b1, 16'hFFFE, 32'h0000_00FC);
        fetch("at fc", 32'hFC, 32'h0, 1);
        accept("fc seq", 1'b0, 1'b0, 16'd0, 32'h100);
        fetch("br2", 32'h100, 32'h1000_0003, 0);
        accept("branch fwd", 1'b0, 1'b1, 16'h0003, 32'h0000_0110);

        // Flush while a read is outstanding; memory answers 4 cycles late
        flush    = 1'b1;
        flush_pc = 32'h0000_0203;
        @(negedge clk);
        flush = 1'b0;
        check("drain pc", pc, 32'h200);
        for (int i = 0; i < 3; i++) begin
            check("drain req", {31'd0, imem_req}, 32'd1);
            check("drain addr", imem_addr, 32'h110);
            check("drain valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_valid = 1'b0;
        check("drained valid", {31'd0, instr_valid}, 32'd0);
        check("drained instr kept", instr, 32'h1000_0003);
        check("drained addr", imem_addr, 32'h200);

        // Flush coinciding with read data: data dropped, restart at 0xFFFF_FFFC
        flush      = 1'b1;
        flush_pc   = 32'hFFFF_FFFF;
        imem_valid = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        flush      = 1'b0;
        imem_valid = 1'b0;
        check("flush+valid instr_valid", {31'd0, instr_valid}, 32'd0);
        check("flush+valid instr", instr, 32'h1000_0003);

        // PC wrap at the top of the address space
        fetch("top", 32'hFFFF_FFFC, 32'h0000_0000, 0);
        check("wrap pc_plus4", pc_plus4, 32'h0);
        accept("wrap", 1'b0, 1'b0, 16'd0, 32'h0);
        fetch("at0", 32'h0, 32'h2409_0001, 0);
        accept("to4", 1'b0, 1'b0, 16'd0, 32'h4);

        // Flush into DRAIN, second flush, then reset mid-DRAIN
        flush    = 1'b1;
        flush_pc = 32'h0000_0040;
        @(negedge clk);
        flush_pc = 32'h0000_0080;
        @(negedge clk);
        flush = 1'b0;
        check("drain2 pc", pc, 32'h80);
        check("drain2 addr", imem_addr, 32'h4);
        check("drain2 req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid-drain reset req", {31'd0, imem_req}, 32'd0);
        check("mid-drain reset instr", instr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        fetch("post reset", 32'h0, 32'h2008_0005, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies 32-bit MIPS instruction words to the main decode controller and owns the program counter.
- Issues one read at a time to instruction memory through a req/valid handshake.
- Holds the fetched word stable until the downstream stage accepts it.
- Computes the next PC from the jump/branch redirect signals produced by decode and execute, and supports a pipeline flush that correctly drains an in-flight memory read.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, program counter and memory address width (fixed at 32 for MIPS; the parameter exists for documentation only).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- imem_req  output  1  read request to instruction memory; held high until imem_valid is sampled.
- imem_addr  output  32  word-aligned read address; bits [1:0] are always 00.
- imem_valid  input  1  read data valid; sampled only while a read is outstanding.
- imem_rdata  input  32  instruction word returned by memory.
- instr  output  32  instruction presented to decode.
- instr_valid  output  1  instr, pc and pc_plus4 are valid.
- pc  output  32  address of the presented instr.
- pc_plus4  output  32  pc + 4.
- stall  input  1  decode back-pressure; the instruction is accepted at a rising edge where instr_valid=1 and stall=0.
- jump  input  1  from decode; qualified only on acceptance.
- branch_taken  input  1  resolved branch; qualified only on acceptance.
- branch_offset  input  16  signed word offset for the branch.
- flush  input  1  kill the current instruction and refetch from flush_pc.
- flush_pc  input  32  restart address; bits [1:0] are ignored and forced to 00.

Behaviour:
- States: REQ, HOLD, DRAIN.
- Reset (synchronous, highest priority):
  - state=REQ, pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, instr_valid=0.
  - imem_req=0 in the reset cycle.
  - imem_req=1 and imem_addr=RESET_PC in the first cycle after reset deasserts.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_valid=1: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - Latency from the imem_valid edge to instr_valid is 1 cycle.
- HOLD:
  - imem_req=0; instr, pc and instr_valid are held while stall=1.
  - On acceptance, compute the next PC, drop instr_valid, and go to REQ at the new pc. Next-PC priority:
    - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
    - else branch_taken: pc_plus4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}), modulo 2^32.
    - else pc_plus4.
  - jump and branch_taken asserted together: jump wins.
  - pc_plus4 is always pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Peak throughput is one instruction per 2 cycles; no prefetch.
- flush (below reset, above everything else):
  - pc<=flush_pc&~3, instr_valid<=0.
  - Flush in REQ with imem_valid=0: go to DRAIN.
  - Flush in REQ with imem_valid=1 at the same edge: data is discarded, go to REQ at the new pc.
  - Flush in HOLD: go to REQ at the new pc; any jump or branch is ignored.
- DRAIN:
  - imem_req=1 with imem_addr held at the old address so the outstanding read completes.
  - On imem_valid: discard the data, go to REQ at the flushed pc.
  - A second flush in DRAIN updates pc and stays in DRAIN.
- imem_rdata is never captured outside REQ.
- instr_valid is never asserted in the same cycle as imem_req.
- Reset in any state, including DRAIN, returns to REQ at RESET_PC.
- Memory must tolerate an abandoned request on reset.

Test Plan:
- Reset, then memory returns 0x20080005 one cycle after req -> imem_addr=0; instr=0x20080005, instr_valid=1, pc=0; after acceptance the next imem_addr=4.
- stall held 3 cycles in HOLD -> instr, pc and instr_valid stay constant, no new req; on release the next fetch addr is pc+4.
- pc=0x0040_0010, instr=0x08100020, jump=1 on acceptance -> next imem_addr=0x0040_0080; with branch_taken also 1, jump still wins.
- pc=0x100, branch_taken=1, branch_offset=16'hFFFE -> next addr 0xFC; with offset 16'h0003 -> next addr 0x110.
- flush (flush_pc=0x203) while in REQ with memory 4 cycles late -> DRAIN; the late word is dropped, instr_valid stays 0, next imem_addr=0x200.
- pc=0xFFFF_FFFC accepted with no redirect -> pc_plus4 was 0, next addr 0; reset asserted mid-DRAIN -> imem_addr=RESET_PC after release.
